// File: rtl/vex_axi_arb_pkg.sv
// vex_axi_arb_pkg: shared state, AR payload type and AXI encodings for the
// VexRiscv read-port arbiter.
package vex_axi_arb_pkg;
    localparam int AR_ADDR_W = 32;
    localparam int AR_ID_W   = 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [AR_ADDR_W-1:0] addr;
        logic [AR_ID_W-1:0]   id;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [2:0]           prot;
    } ar_t;
endpackage

// File: rtl/vex_rr_arb2.sv
// vex_rr_arb2: two-way round-robin grant; on a tie the port not granted last wins.
module vex_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       grant_valid_o
);
    assign grant_o       = &valid_i ? !last_grant_i : valid_i[1];
    assign grant_valid_o = |valid_i;
endmodule

// File: rtl/vex_axi_rd_arbiter.sv
// vex_axi_rd_arbiter: shares one AXI4 read master between the VexRiscv IMEM (port 0)
// and DMEM (port 1) buses, one burst at a time, with an RLAST/ARLEN consistency check.
module vex_axi_rd_arbiter
    import vex_axi_arb_pkg::*;
#(
    parameter int C_ADDR_WIDTH = AR_ADDR_W,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ID_WIDTH   = AR_ID_W
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [C_ADDR_WIDTH-1:0] s0_araddr,
    input  logic [C_ID_WIDTH-1:0]   s0_arid,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    input  logic [2:0]              s0_arprot,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    output logic [C_DATA_WIDTH-1:0] s0_rdata,
    output logic [C_ID_WIDTH-1:0]   s0_rid,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rlast,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    input  logic [C_ADDR_WIDTH-1:0] s1_araddr,
    input  logic [C_ID_WIDTH-1:0]   s1_arid,
    input  logic [7:0]              s1_arlen,
    input  logic [2:0]              s1_arsize,
    input  logic [1:0]              s1_arburst,
    input  logic [2:0]              s1_arprot,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    output logic [C_DATA_WIDTH-1:0] s1_rdata,
    output logic [C_ID_WIDTH-1:0]   s1_rid,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rlast,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [C_ADDR_WIDTH-1:0] m_araddr,
    output logic [C_ID_WIDTH-1:0]   m_arid,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [C_DATA_WIDTH-1:0] m_rdata,
    input  logic [C_ID_WIDTH-1:0]   m_rid,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic                    grant_o,
    output logic                    busy_o,
    output logic                    proto_err_o
);
    state_t     state_q, state_d;
    ar_t        ar_q, ar_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       proto_err_q, proto_err_d;
    logic       gnt, gnt_valid, ar_hs, beat, in_data, route0, route1;

    vex_rr_arb2 u_arb (
        .valid_i      ({s1_arvalid, s0_arvalid}),
        .last_grant_i (last_grant_q),
        .grant_o      (gnt),
        .grant_valid_o(gnt_valid)
    );

    // arready is combinational, so it is gated by ARESET to drop with the flops
    assign s0_arready = !ARESET && state_q == IDLE && gnt_valid && !gnt;
    assign s1_arready = !ARESET && state_q == IDLE && gnt_valid && gnt;
    assign ar_hs      = s0_arready || s1_arready;

    assign in_data  = state_q == DATA;
    assign route0   = in_data && !last_grant_q;
    assign route1   = in_data && last_grant_q;
    assign m_rready = in_data && (last_grant_q ? s1_rready : s0_rready);
    assign beat     = m_rvalid && m_rready;

    assign s0_rvalid = route0 && m_rvalid;
    assign s0_rdata  = route0 ? m_rdata : '0;
    assign s0_rid    = route0 ? m_rid : '0;
    assign s0_rresp  = route0 ? m_rresp : '0;
    assign s0_rlast  = route0 && m_rlast;
    assign s1_rvalid = route1 && m_rvalid;
    assign s1_rdata  = route1 ? m_rdata : '0;
    assign s1_rid    = route1 ? m_rid : '0;
    assign s1_rresp  = route1 ? m_rresp : '0;
    assign s1_rlast  = route1 && m_rlast;

    assign m_arvalid   = state_q == ADDR;
    assign m_araddr    = ar_q.addr;
    assign m_arid      = ar_q.id;
    assign m_arlen     = ar_q.len;
    assign m_arsize    = ar_q.size;
    assign m_arburst   = ar_q.burst;
    assign m_arprot    = ar_q.prot;
    assign grant_o     = last_grant_q;
    assign busy_o      = state_q != IDLE;
    assign proto_err_o = proto_err_q;

    always_comb begin
        state_d      = state_q;
        ar_d         = ar_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        proto_err_d  = proto_err_q;
        if (ar_hs) begin
            state_d      = ADDR;
            last_grant_d = gnt;
            beat_cnt_d   = '0;
            ar_d         = gnt ? {s1_araddr, s1_arid, s1_arlen, s1_arsize, s1_arburst, s1_arprot}
                               : {s0_araddr, s0_arid, s0_arlen, s0_arsize, s0_arburst, s0_arprot};
        end
        if (state_q == ADDR && m_arready)
            state_d = DATA;
        // a burst only ends on RLAST; a count mismatch is flagged but not acted on
        if (beat) begin
            beat_cnt_d  = beat_cnt_q + 8'd1;
            proto_err_d = proto_err_q || (m_rlast != (beat_cnt_q == ar_q.len));
            state_d     = m_rlast ? IDLE : state_d;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            ar_q         <= '0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ar_q         <= ar_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_vex_axi_rd_arbiter.sv
// tb_vex_axi_rd_arbiter: randomized requesters and slave around the read arbiter,
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_vex_axi_rd_arbiter;
    import vex_axi_arb_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        id;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  prot;
    } req_t;
    typedef struct {
        logic [31:0] data;
        logic        id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;
    typedef struct {
        logic [31:0] addr;
        logic        id;
        int          last;
    } sb_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] s_araddr [2];
    logic        s_arid [2];
    logic [7:0]  s_arlen [2];
    logic [2:0]  s_arsize [2];
    logic [1:0]  s_arburst [2];
    logic [2:0]  s_arprot [2];
    logic        s_arvalid [2];
    logic        s_arready [2];
    logic [31:0] s_rdata [2];
    logic        s_rid [2];
    logic [1:0]  s_rresp [2];
    logic        s_rlast [2];
    logic        s_rvalid [2];
    logic        s_rready [2];
    logic [31:0] m_araddr, m_rdata;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize, m_arprot;
    logic [1:0]  m_arburst, m_rresp;
    logic        m_arid, m_arvalid, m_arready, m_rid, m_rlast, m_rvalid, m_rready;
    logic        grant_o, busy_o, proto_err_o;

    int    chk = 0;
    int    pass = 0;
    req_t  req_q [2][$];
    beat_t exp_q [2][$];
    int    glog [$];
    int    rcv_cnt [2];
    int    ar_stall = 0;
    int    early_last = -1;
    int    rr_mode [2];
    bit    slave_gaps = 0;

    bit    mbusy = 0, mlast = 1, mpend = 0, mproto = 0;
    req_t  mreq;
    int    mcnt;
    logic  g, dat;
    logic  ea [2];
    beat_t b;

    vex_axi_rd_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s0_araddr(s_araddr[0]), .s0_arid(s_arid[0]), .s0_arlen(s_arlen[0]), .s0_arsize(s_arsize[0]),
        .s0_arburst(s_arburst[0]), .s0_arprot(s_arprot[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
        .s0_rdata(s_rdata[0]), .s0_rid(s_rid[0]), .s0_rresp(s_rresp[0]), .s0_rlast(s_rlast[0]),
        .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
        .s1_araddr(s_araddr[1]), .s1_arid(s_arid[1]), .s1_arlen(s_arlen[1]), .s1_arsize(s_arsize[1]),
        .s1_arburst(s_arburst[1]), .s1_arprot(s_arprot[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
        .s1_rdata(s_rdata[1]), .s1_rid(s_rid[1]), .s1_rresp(s_rresp[1]), .s1_rlast(s_rlast[1]),
        .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
        .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .grant_o(grant_o), .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    always #5 ACLK = !ACLK;

    function automatic logic [31:0] bdata(input logic [31:0] a, input int i);
        logic [7:0] lo;
        lo = 8'hA0 + 8'(i);
        return {a[23:0], lo};
    endfunction

    function automatic logic [1:0] bresp(input logic [31:0] a, input int i);
        return {1'b0, a[4] ^ i[0]};
    endfunction

    task automatic requester(input int p);
        bit   hs = 0;
        req_t r;
        int   nb;
        forever begin
            @(negedge ACLK);
            if (ARESET || hs) begin
                s_arvalid[p] = 1'b0;
                hs = 0;
            end
            if (!ARESET && !s_arvalid[p] && req_q[p].size() > 0) begin
                r = req_q[p].pop_front();
                s_araddr[p] = r.addr; s_arid[p] = r.id; s_arlen[p] = r.len;
                s_arsize[p] = r.size; s_arburst[p] = r.burst; s_arprot[p] = r.prot;
                s_arvalid[p] = 1'b1;
            end
            s_rready[p] = rr_mode[p] == 0 ? 1'b1 : rr_mode[p] == 1 ? 1'($urandom) : !s_rready[p];
            #2;
            hs = s_arvalid[p] && s_arready[p];
            if (hs) begin
                glog.push_back(p);
                nb = early_last >= 0 ? early_last : int'(s_arlen[p]);
                for (int i = 0; i <= nb; i++)
                    exp_q[p].push_back('{bdata(s_araddr[p], i), s_arid[p], bresp(s_araddr[p], i), i == nb});
            end
        end
    endtask

    task automatic slave();
        bit  ar_hs = 0, r_hs = 0, active = 0;
        int  beat = 0;
        sb_t cur, bq [$];
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
                bq.delete(); active = 0; ar_hs = 0; r_hs = 0;
            end else begin
                if (r_hs) begin
                    if (m_rlast) active = 0;
                    else beat++;
                end
                if (!active && bq.size() > 0) begin
                    cur = bq.pop_front();
                    active = 1;
                    beat = 0;
                end
                if (r_hs || !m_rvalid) begin
                    m_rvalid = active && (!slave_gaps || $urandom_range(0, 3) != 0);
                    m_rdata = bdata(cur.addr, beat);
                    m_rresp = bresp(cur.addr, beat);
                    m_rid = cur.id;
                    m_rlast = beat == cur.last;
                end
                if (ar_stall > 0) begin
                    m_arready = 1'b0;
                    if (m_arvalid) ar_stall--;
                end else
                    m_arready = slave_gaps ? 1'($urandom) : 1'b1;
            end
            #2;
            ar_hs = m_arvalid && m_arready;
            r_hs = m_rvalid && m_rready;
            if (ar_hs && !ARESET) begin
                bq.push_back('{m_araddr, m_arid, early_last >= 0 ? early_last : int'(m_arlen)});
                early_last = -1;
            end
        end
    endtask

    // cycle-level monitor: arbitration rules, AR latency/stability, R routing, beat order
    always @(negedge ACLK) begin
        #3;
        if (ARESET) begin
            mbusy = 0; mlast = 1; mpend = 0; mproto = 0;
        end else begin
            g = (s_arvalid[0] && s_arvalid[1]) ? !mlast : s_arvalid[1];
            dat = mbusy && !mpend;
            for (int p = 0; p < 2; p++) begin
                ea[p] = !mbusy && s_arvalid[p] && (g == p[0]);
                chk++;
                if (s_arready[p] !== ea[p]) $display("FAIL arready%0d: got %b want %b", p, s_arready[p], ea[p]);
                else pass++;
                chk++;
                if (s_rvalid[p] !== (dat && mlast == p[0] && m_rvalid))
                    $display("FAIL rvalid%0d: got %b want %b", p, s_rvalid[p], dat && mlast == p[0] && m_rvalid);
                else pass++;
                chk++;
                if ({s_rdata[p], s_rid[p], s_rresp[p], s_rlast[p]} !==
                    ((dat && mlast == p[0]) ? {m_rdata, m_rid, m_rresp, m_rlast} : 36'h0))
                    $display("FAIL rpayload%0d: got %h", p, {s_rdata[p], s_rid[p], s_rresp[p], s_rlast[p]});
                else pass++;
                if (s_rvalid[p] && s_rready[p]) begin
                    chk++;
                    if (exp_q[p].size() == 0) $display("FAIL extra_beat%0d: got %h want none", p, s_rdata[p]);
                    else begin
                        b = exp_q[p].pop_front();
                        if ({s_rdata[p], s_rid[p], s_rresp[p], s_rlast[p]} !== {b.data, b.id, b.resp, b.last})
                            $display("FAIL beat%0d: got %h/%b/%h/%b want %h/%b/%h/%b", p, s_rdata[p], s_rid[p],
                                     s_rresp[p], s_rlast[p], b.data, b.id, b.resp, b.last);
                        else pass++;
                    end
                    rcv_cnt[p]++;
                end
            end
            chk++;
            if (m_rready !== (dat && s_rready[mlast])) $display("FAIL m_rready: got %b want %b", m_rready, dat && s_rready[mlast]);
            else pass++;
            chk++;
            if (m_arvalid !== mpend) $display("FAIL m_arvalid: got %b want %b", m_arvalid, mpend);
            else pass++;
            if (mpend) begin
                chk++;
                if ({m_araddr, m_arlen, m_arid, m_arsize, m_arburst, m_arprot} !==
                    {mreq.addr, mreq.len, mreq.id, mreq.size, mreq.burst, mreq.prot})
                    $display("FAIL ar_payload: got %h/%h want %h/%h", m_araddr, m_arlen, mreq.addr, mreq.len);
                else pass++;
            end
            chk++;
            if ({busy_o, grant_o, proto_err_o} !== {mbusy, mlast, mproto})
                $display("FAIL status: got busy/grant/err %b%b%b want %b%b%b", busy_o, grant_o, proto_err_o, mbusy, mlast, mproto);
            else pass++;
            if (ea[0] || ea[1]) begin
                mbusy = 1; mpend = 1; mlast = g; mcnt = 0;
                mreq = '{s_araddr[g], s_arlen[g], s_arid[g], s_arsize[g], s_arburst[g], s_arprot[g]};
            end else if (mpend && m_arready) mpend = 0;
            else if (dat && m_rvalid && s_rready[mlast]) begin
                if (m_rlast != (mcnt == int'(mreq.len))) mproto = 1;
                mcnt = (mcnt + 1) & 255;
                if (m_rlast) mbusy = 0;
            end
        end
    end

    function automatic req_t mk(input logic [31:0] a, input logic [7:0] l);
        return '{a, l, 1'($urandom), 3'($urandom_range(0, 2)), BURST_INCR, 3'($urandom)};
    endfunction

    task automatic wait_done(input int max, output bit ok);
        ok = 0;
        for (int c = 0; c < max && !ok; c++) begin
            @(negedge ACLK); #5;
            ok = req_q[0].size() == 0 && req_q[1].size() == 0 && !s_arvalid[0] && !s_arvalid[1] &&
                 exp_q[0].size() == 0 && exp_q[1].size() == 0 && !mbusy;
        end
        @(negedge ACLK); #4;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ACLK);
        #1;
        chk++;
        if ({s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1], m_arvalid, m_rready, busy_o, proto_err_o, grant_o} !== 9'b000000001)
            $display("FAIL reset_outputs: got %b want 000000001", {s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1],
                     m_arvalid, m_rready, busy_o, proto_err_o, grant_o});
        else pass++;
        chk++;
        if ({m_araddr, m_arlen, m_arid, m_arprot} !== 44'h0) $display("FAIL reset_payload: got %h want 0", m_araddr);
        else pass++;
        ARESET = 1'b0;
    endtask

    task automatic test_tie();
        bit ok;
        for (int k = 0; k < 2; k++) begin
            glog.delete();
            req_q[0].push_back(mk(32'h0000_2000 + 32'(k * 256), 8'd1));
            req_q[1].push_back(mk(32'h0000_3000 + 32'(k * 256), 8'd2));
            wait_done(200, ok);
            chk++;
            if (!ok) $display("FAIL tie_timeout%0d: got busy want idle", k);
            else pass++;
            chk++;
            if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1) $display("FAIL tie_order%0d: got %p want 0,1", k, glog);
            else pass++;
        end
    endtask

    task automatic test_single_imem();
        bit ok;
        int r0 = rcv_cnt[0], r1 = rcv_cnt[1];
        glog.delete();
        req_q[0].push_back(mk(32'h0000_1000, 8'd3));
        wait_done(200, ok);
        chk++;
        if (!ok || rcv_cnt[0] - r0 != 4 || rcv_cnt[1] != r1)
            $display("FAIL single_imem: got beats %0d/%0d want 4/0", rcv_cnt[0] - r0, rcv_cnt[1] - r1);
        else pass++;
        chk++;
        if (grant_o !== 1'b0) $display("FAIL single_grant: got %b want 0", grant_o);
        else pass++;
    endtask

    task automatic test_alternate();
        bit ok;
        bit first = !mlast;
        glog.delete();
        rr_mode[0] = 1; rr_mode[1] = 1; slave_gaps = 1;
        for (int i = 0; i < 4; i++) begin
            req_q[0].push_back(mk({$urandom} & 32'hFFFF_FFF0, 8'($urandom_range(0, 5))));
            req_q[1].push_back(mk({$urandom} & 32'hFFFF_FFF0, 8'($urandom_range(0, 5))));
        end
        wait_done(2000, ok);
        chk++;
        if (!ok || glog.size() != 8) $display("FAIL alt_count: got %0d want 8", glog.size());
        else pass++;
        for (int i = 0; i < glog.size(); i++) begin
            chk++;
            if (glog[i] != ((int'(first) + i) % 2)) $display("FAIL alt_grant%0d: got %0d want %0d", i, glog[i], (int'(first) + i) % 2);
            else pass++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int r1 = rcv_cnt[1];
        rr_mode[1] = 2; slave_gaps = 0; ar_stall = 5;
        req_q[1].push_back(mk({$urandom} & 32'hFFFF_FFF0, 8'd7));
        wait_done(400, ok);
        chk++;
        if (!ok || rcv_cnt[1] - r1 != 8) $display("FAIL backpressure: got %0d beats want 8", rcv_cnt[1] - r1);
        else pass++;
    endtask

    task automatic test_proto_err();
        bit ok;
        int r0 = rcv_cnt[0], r1 = rcv_cnt[1];
        rr_mode[0] = 1; rr_mode[1] = 0;
        chk++;
        if (proto_err_o !== 1'b0) $display("FAIL proto_before: got %b want 0", proto_err_o);
        else pass++;
        early_last = 2;
        req_q[0].push_back(mk(32'h0000_4000, 8'd3));
        wait_done(300, ok);
        chk++;
        if (!ok || proto_err_o !== 1'b1 || busy_o !== 1'b0 || rcv_cnt[0] - r0 != 3)
            $display("FAIL proto_set: got err %b busy %b beats %0d want 1 0 3", proto_err_o, busy_o, rcv_cnt[0] - r0);
        else pass++;
        req_q[1].push_back(mk(32'h0000_5000, 8'd2));
        wait_done(300, ok);
        chk++;
        if (!ok || proto_err_o !== 1'b1 || rcv_cnt[1] - r1 != 3)
            $display("FAIL proto_sticky: got err %b beats %0d want 1 3", proto_err_o, rcv_cnt[1] - r1);
        else pass++;
    endtask

    task automatic test_random();
        bit ok;
        int want = 0, r = rcv_cnt[0] + rcv_cnt[1];
        req_t q;
        slave_gaps = 1;
        for (int i = 0; i < 24; i++) begin
            q = mk({$urandom} & 32'hFFFF_FFF0, 8'($urandom_range(0, 15)));
            want += int'(q.len) + 1;
            req_q[$urandom_range(0, 1)].push_back(q);
            if (i % 6 == 0) begin
                rr_mode[0] = $urandom_range(0, 2);
                rr_mode[1] = $urandom_range(0, 2);
            end
        end
        wait_done(8000, ok);
        chk++;
        if (!ok || rcv_cnt[0] + rcv_cnt[1] - r != want)
            $display("FAIL random_beats: got %0d want %0d", rcv_cnt[0] + rcv_cnt[1] - r, want);
        else pass++;
    endtask

    task automatic test_reset_mid_burst();
        bit ok = 0;
        int r0 = rcv_cnt[0];
        rr_mode[0] = 0; slave_gaps = 0;
        req_q[0].push_back(mk(32'h0000_6000, 8'd3));
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge ACLK); #5;
            ok = rcv_cnt[0] > r0;
        end
        chk++;
        if (!ok) $display("FAIL mid_wait: got %0d beats want 1", rcv_cnt[0] - r0);
        else pass++;
        @(posedge ACLK); #1;
        chk++;
        if (busy_o !== 1'b1 || grant_o !== 1'b0) $display("FAIL mid_pre: got busy %b grant %b want 1 0", busy_o, grant_o);
        else pass++;
        ARESET = 1'b1;
        #1;
        chk++;
        if ({s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1], m_arvalid, m_rready, busy_o, proto_err_o, grant_o} !== 9'b000000001)
            $display("FAIL mid_reset: got %b want 000000001", {s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1],
                     m_arvalid, m_rready, busy_o, proto_err_o, grant_o});
        else pass++;
        exp_q[0].delete();
        @(negedge ACLK); @(negedge ACLK); #1;
        ARESET = 1'b0;
        r0 = rcv_cnt[0];
        glog.delete();
        req_q[0].push_back(mk(32'h0000_7000, 8'd1));
        wait_done(200, ok);
        chk++;
        if (!ok || glog.size() != 1 || glog[0] != 0 || rcv_cnt[0] - r0 != 2)
            $display("FAIL post_reset: got %0d grants %0d beats want 1 2", glog.size(), rcv_cnt[0] - r0);
        else pass++;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            s_arvalid[p] = 1'b0; s_rready[p] = 1'b1; rr_mode[p] = 0; rcv_cnt[p] = 0;
            s_araddr[p] = '0; s_arid[p] = 1'b0; s_arlen[p] = '0; s_arsize[p] = '0; s_arburst[p] = '0; s_arprot[p] = '0;
        end
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = 1'b0; m_rresp = '0; m_rlast = 1'b0;
        fork
            requester(0);
            requester(1);
            slave();
        join_none
        test_reset();
        test_tie();
        test_single_imem();
        test_alternate();
        test_backpressure();
        test_random();
        test_proto_err();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
